// File: rtl/dino_renderer_if.sv
// Pixel-request and game-status bundle between the LCD timing driver and the
// dino game renderer.
interface dino_renderer_if;
   logic [10:0] pixel_xpos;
   logic [10:0] pixel_ypos;
   logic [10:0] h_disp;
   logic [10:0] v_disp;
   logic        jump;
   logic [23:0] pixel_data;
   logic        game_over;
   logic [15:0] score;

   modport master (
      output pixel_xpos, pixel_ypos, h_disp, v_disp, jump,
      input  pixel_data, game_over, score
   );

   modport slave (
      input  pixel_xpos, pixel_ypos, h_disp, v_disp, jump,
      output pixel_data, game_over, score
   );
endinterface

// File: rtl/dino_renderer.sv
// Side-scrolling dino game: per-frame game state machine plus a one-cycle
// registered pixel colour lookup for the LCD driver.
module dino_renderer #(
   parameter logic [10:0] GROUND_Y      = 11'd200,
   parameter logic [10:0] DINO_X        = 11'd40,
   parameter int          DINO_W        = 20,
   parameter int          DINO_H        = 24,
   parameter int          CACTUS_W      = 12,
   parameter int          CACTUS_H      = 24,
   parameter logic [10:0] INIT_CACTUS_X = 11'd400,
   parameter int          SPEED         = 4,
   parameter int          JUMP_V0       = 12,
   parameter int          GRAVITY       = 1
) (
   input  logic             lcd_pclk,
   input  logic             rst_n,
   dino_renderer_if.slave   lcd
);

   typedef enum logic [1:0] {GROUND, AIR, OVER} state_t;

   localparam logic [11:0]        GY_C     = {1'b0, GROUND_Y};
   localparam logic [11:0]        DX_C     = {1'b0, DINO_X};
   localparam logic [11:0]        DW_C     = 12'(DINO_W);
   localparam logic [11:0]        DH_C     = 12'(DINO_H);
   localparam logic [11:0]        CW_C     = 12'(CACTUS_W);
   localparam logic [11:0]        CH_C     = 12'(CACTUS_H);
   localparam logic [7:0]         CH8_C    = 8'(CACTUS_H);
   localparam logic [10:0]        SPEED_C  = 11'(SPEED);
   localparam logic signed [6:0]  JUMP_C   = 7'(JUMP_V0);
   localparam logic signed [6:0]  GRAV_C   = 7'(GRAVITY);

   state_t             state_q;
   logic [7:0]         h_q;
   logic signed [6:0]  vel_q;
   logic [10:0]        cactus_x_q;
   logic [15:0]        score_q;
   logic               game_over_q;
   logic [23:0]        pixel_data_q, pixel_data_d;
   logic [1:0]         jump_sync_q;
   logic               jump_prev_q;
   logic               jump_req_q, jump_req_d;

   logic               jump_rise;
   logic               frame_tick;
   logic               collide;
   logic signed [9:0]  air_sum;
   logic [11:0]        sx, sy, h12, cx12;
   logic               in_dino, in_cactus;

   assign jump_rise  = jump_sync_q[1] & ~jump_prev_q;
   assign frame_tick = (lcd.pixel_xpos != 11'd0) && (lcd.pixel_xpos == lcd.h_disp)
                       && (lcd.pixel_ypos == lcd.v_disp);

   // A button edge landing on the tick cycle is kept for the following frame.
   always_comb begin
      jump_req_d = jump_req_q;
      if (frame_tick) jump_req_d = 1'b0;
      if (jump_rise)  jump_req_d = 1'b1;
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         jump_sync_q <= 2'b00;
         jump_prev_q <= 1'b0;
         jump_req_q  <= 1'b0;
      end else begin
         jump_sync_q <= {jump_sync_q[0], lcd.jump};
         jump_prev_q <= jump_sync_q[1];
         jump_req_q  <= jump_req_d;
      end
   end

   assign h12     = {4'b0000, h_q};
   assign cx12    = {1'b0, cactus_x_q};
   assign collide = (cx12 < DX_C + DW_C) && (cx12 + CW_C > DX_C) && (h_q < CH8_C);
   assign air_sum = $signed({2'b00, h_q}) + $signed({{3{vel_q[6]}}, vel_q});

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= GROUND;
         h_q         <= 8'd0;
         vel_q       <= 7'sd0;
         cactus_x_q  <= INIT_CACTUS_X;
         score_q     <= 16'd0;
         game_over_q <= 1'b0;
      end else if (frame_tick) begin
         case (state_q)
            GROUND, AIR: begin
               if (collide) begin
                  state_q     <= OVER;
                  game_over_q <= 1'b1;
               end else begin
                  if (state_q == GROUND) begin
                     if (jump_req_q) begin
                        state_q <= AIR;
                        vel_q   <= JUMP_C;
                     end
                  end else if (air_sum <= 10'sd0) begin
                     h_q     <= 8'd0;
                     vel_q   <= 7'sd0;
                     state_q <= GROUND;
                  end else begin
                     h_q   <= air_sum[7:0];
                     vel_q <= vel_q - GRAV_C;
                  end
                  if (cactus_x_q < SPEED_C) begin
                     cactus_x_q <= lcd.h_disp - 11'd1;
                     if (score_q != 16'hFFFF) score_q <= score_q + 16'd1;
                  end else begin
                     cactus_x_q <= cactus_x_q - SPEED_C;
                  end
               end
            end
            OVER: begin
               if (jump_req_q) begin
                  state_q     <= GROUND;
                  h_q         <= 8'd0;
                  vel_q       <= 7'sd0;
                  cactus_x_q  <= INIT_CACTUS_X;
                  score_q     <= 16'd0;
                  game_over_q <= 1'b0;
               end
            end
            default: state_q <= GROUND;
         endcase
      end
   end

   // Screen coordinates are one less than the driver's 1-based request.
   assign sx = {1'b0, lcd.pixel_xpos} - 12'd1;
   assign sy = {1'b0, lcd.pixel_ypos} - 12'd1;

   assign in_dino   = (sx >= DX_C) && (sx < DX_C + DW_C)
                      && (sy >= GY_C - h12 - DH_C) && (sy < GY_C - h12);
   assign in_cactus = (sx >= cx12) && (sx < cx12 + CW_C)
                      && (sy >= GY_C - CH_C) && (sy < GY_C);

   always_comb begin
      pixel_data_d = 24'hFFFFFF;
      if (lcd.pixel_xpos == 11'd0 || lcd.pixel_ypos == 11'd0)
         pixel_data_d = 24'h000000;
      else if (in_dino)
         pixel_data_d = (state_q == OVER) ? 24'hFF0000 : 24'h535353;
      else if (in_cactus)
         pixel_data_d = 24'h2E7D32;
      else if (sy == GY_C)
         pixel_data_d = 24'h000000;
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) pixel_data_q <= 24'h000000;
      else        pixel_data_q <= pixel_data_d;
   end

   assign lcd.pixel_data = pixel_data_q;
   assign lcd.game_over  = game_over_q;
   assign lcd.score      = score_q;

endmodule

// File: tb/tb_dino_renderer.sv
// Scoreboard bench for dino_renderer: a behavioural game model predicts each
// requested pixel and the per-frame game state.
module tb_dino_renderer;

   logic lcd_pclk = 1'b0;
   logic rst_n;
   always #5 lcd_pclk = ~lcd_pclk;

   dino_renderer_if lcd();
   dino_renderer dut (.lcd_pclk(lcd_pclk), .rst_n(rst_n), .lcd(lcd));

   int n_checks = 0;
   int n_fail   = 0;

   int m_state, m_h, m_vel, m_cx, m_score;
   bit m_req;
   logic [23:0] sb_q[$];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_h = 0; m_vel = 0; m_cx = 400; m_score = 0; m_req = 0;
   endtask

   function automatic logic [23:0] exp_colour(input int xp, input int yp);
      int x, y;
      if (xp == 0 || yp == 0) return 24'h000000;
      x = xp - 1; y = yp - 1;
      if (x >= 40 && x < 60 && y >= 200 - m_h - 24 && y < 200 - m_h)
         return (m_state == 2) ? 24'hFF0000 : 24'h535353;
      if (x >= m_cx && x < m_cx + 12 && y >= 176 && y < 200) return 24'h2E7D32;
      if (y == 200) return 24'h000000;
      return 24'hFFFFFF;
   endfunction

   task automatic model_tick();
      if (m_state == 2) begin
         if (m_req) begin
            m_state = 0; m_h = 0; m_vel = 0; m_cx = 400; m_score = 0;
         end
      end else if (m_cx < 60 && m_cx + 12 > 40 && m_h < 24) begin
         m_state = 2;
      end else begin
         if (m_state == 0) begin
            if (m_req) begin m_state = 1; m_vel = 12; end
         end else if (m_h + m_vel <= 0) begin
            m_h = 0; m_vel = 0; m_state = 0;
         end else begin
            m_h = m_h + m_vel; m_vel = m_vel - 1;
         end
         if (m_cx < 4) begin
            m_cx = 479;
            if (m_score < 65535) m_score++;
         end else m_cx = m_cx - 4;
      end
      m_req = 0;
   endtask

   task automatic req_exp(input int xp, input int yp, input logic [23:0] exp);
      logic [23:0] e;
      sb_q.push_back(exp);
      lcd.pixel_xpos = 11'(xp);
      lcd.pixel_ypos = 11'(yp);
      @(posedge lcd_pclk); #1;
      e = sb_q.pop_front();
      check_val("pix", {8'h00, lcd.pixel_data}, {8'h00, e});
   endtask

   task automatic req(input int xp, input int yp);
      req_exp(xp, yp, exp_colour(xp, yp));
   endtask

   task automatic tick();
      req(480, 272);
      model_tick();
      check_val("h",     {24'h0, dut.h_q}, 32'(m_h));
      check_val("cx",    {21'h0, dut.cactus_x_q}, 32'(m_cx));
      check_val("over",  {31'h0, lcd.game_over}, (m_state == 2) ? 32'd1 : 32'd0);
      check_val("score", {16'h0, lcd.score}, 32'(m_score));
      req(0, 0);
      req(41, 177);
      req(41, 200 - m_h - 24 + 1);
      req(m_cx + 1, 190);
      req(1, 201);
   endtask

   task automatic pulse_jump();
      lcd.jump = 1'b1;
      repeat (3) req(0, 0);
      lcd.jump = 1'b0;
      repeat (3) req(0, 0);
      m_req = 1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int exp_h [25] = '{12,23,33,42,50,57,63,68,72,75,77,78,78,77,75,72,68,63,57,50,42,33,23,12,0};
      int peak;
      int guard;

      rst_n = 1'b0;
      lcd.pixel_xpos = 11'd41; lcd.pixel_ypos = 11'd177;
      lcd.h_disp = 11'd480; lcd.v_disp = 11'd272; lcd.jump = 1'b0;
      model_reset();
      repeat (3) @(posedge lcd_pclk);
      #1;
      check_val("rst_pix",   {8'h00, lcd.pixel_data}, 32'h0);
      check_val("rst_over",  {31'h0, lcd.game_over}, 32'd0);
      check_val("rst_score", {16'h0, lcd.score}, 32'd0);
      check_val("rst_cx",    {21'h0, dut.cactus_x_q}, 32'd400);
      @(negedge lcd_pclk);
      rst_n = 1'b1;

      req_exp(41, 177, 24'h535353);
      req_exp(1, 201, 24'h000000);
      req_exp(1, 1, 24'hFFFFFF);
      req_exp(0, 5, 24'h000000);

      // Run into the cactus without jumping.
      for (int t = 1; t <= 87; t++) begin
         tick();
         if (t == 86) check_val("over86", {31'h0, lcd.game_over}, 32'd0);
      end
      check_val("over87", {31'h0, lcd.game_over}, 32'd1);
      check_val("cx87",   {21'h0, dut.cactus_x_q}, 32'd56);
      req_exp(41, 177, 24'hFF0000);
      tick(); tick();
      check_val("cx_frozen", {21'h0, dut.cactus_x_q}, 32'd56);

      // Restart from OVER.
      pulse_jump();
      tick();
      check_val("rs_score", {16'h0, lcd.score}, 32'd0);
      check_val("rs_cx",    {21'h0, dut.cactus_x_q}, 32'd400);
      check_val("rs_over",  {31'h0, lcd.game_over}, 32'd0);
      tick();
      check_val("rs_nojump", {24'h0, dut.h_q}, 32'd0);
      check_val("rs_cx2",    {21'h0, dut.cactus_x_q}, 32'd396);

      // Full jump arc.
      pulse_jump();
      tick();
      check_val("jump_h0", {24'h0, dut.h_q}, 32'd0);
      peak = 0;
      for (int n = 0; n < 25; n++) begin
         tick();
         check_val("arc_h", {24'h0, dut.h_q}, 32'(exp_h[n]));
         if (int'(dut.h_q) > peak) peak = int'(dut.h_q);
      end
      check_val("peak", 32'(peak), 32'd78);
      tick();
      check_val("landed", {24'h0, dut.h_q}, 32'd0);

      // Timed jump clears the cactus, then it wraps.
      guard = 0;
      while (m_cx != 80 && guard < 200) begin tick(); guard++; end
      check_val("reach80", {21'h0, dut.cactus_x_q}, 32'd80);
      pulse_jump();
      guard = 0;
      while (m_cx != 0 && guard < 100) begin tick(); guard++; end
      check_val("reach0", {21'h0, dut.cactus_x_q}, 32'd0);
      tick();
      check_val("wrap_cx",    {21'h0, dut.cactus_x_q}, 32'd479);
      check_val("wrap_score", {16'h0, lcd.score}, 32'd1);
      check_val("wrap_over",  {31'h0, lcd.game_over}, 32'd0);
      check_val("in_air",     {31'h0, dut.h_q != 8'd0}, 32'd1);

      // Asynchronous reset mid-frame while airborne.
      lcd.pixel_xpos = 11'd41; lcd.pixel_ypos = 11'd177;
      @(posedge lcd_pclk); #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_pix",   {8'h00, lcd.pixel_data}, 32'h0);
      check_val("arst_over",  {31'h0, lcd.game_over}, 32'd0);
      check_val("arst_score", {16'h0, lcd.score}, 32'd0);
      @(posedge lcd_pclk); #2;
      rst_n = 1'b1;
      model_reset();
      check_val("arst_h", {24'h0, dut.h_q}, 32'd0);
      req(100, 50);
      req(200, 100);
      req(1, 201);
      check_val("no_tick_cx", {21'h0, dut.cactus_x_q}, 32'd400);
      req_exp(41, 177, 24'h535353);
      tick();
      check_val("post_cx", {21'h0, dut.cactus_x_q}, 32'd396);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
